// File: rtl/s2_kes_sched.sv
// s2_kes_sched: two-lane round-robin scheduler and 1-entry result buffer for a shared t=2 KES engine; KES_SCHED_ZERO_BYPASS_EN short-circuits all-zero syndrome sets
module s2_kes_sched #(
  parameter int WDOG_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syn_vld_a,
  output logic        syn_rdy_a,
  input  logic [31:0] syn_a,
  input  logic        syn_vld_b,
  output logic        syn_rdy_b,
  input  logic [31:0] syn_b,
  output logic        kes_ena,
  output logic [31:0] kes_syn,
  input  logic        kes_done,
  input  logic [23:0] kes_lambda,
  input  logic [15:0] kes_omega,
  output logic        res_vld,
  input  logic        res_rdy,
  output logic        res_lane,
  output logic [23:0] res_lambda,
  output logic [15:0] res_omega,
  output logic        err_wdog,
  output logic        err_stray
);
  logic        bufa_vld, bufb_vld, busy, tag, rr_ptr;
  logic [31:0] bufa, bufb, sel_syn;
  logic [3:0]  wdog;
  logic        sel, can_go, issue, byp, grant, cap;
  assign syn_rdy_a = ~bufa_vld & ~rst;
  assign syn_rdy_b = ~bufb_vld & ~rst;
  assign cap       = busy & kes_done;
  assign grant     = issue | byp;
  // pick a lane, and issue only when engine idle, result slot free and no done pulse this cycle
  always_comb begin
    sel     = (bufa_vld & bufb_vld) ? rr_ptr : ~bufa_vld;
    sel_syn = sel ? bufb : bufa;
    can_go  = (bufa_vld | bufb_vld) & (~res_vld | res_rdy) & ~kes_done;
`ifdef KES_SCHED_ZERO_BYPASS_EN
    byp     = can_go & (sel_syn == 32'h0);
    issue   = can_go & ~busy & (sel_syn != 32'h0);
`else
    byp     = 1'b0;
    issue   = can_go & ~busy;
`endif
    kes_ena = issue;
    kes_syn = issue ? sel_syn : 32'h0;
  end
  // lane buffers load on handshake, free on grant; pointer favours the other lane next time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufa_vld <= 1'b0;
      bufb_vld <= 1'b0;
      bufa     <= '0;
      bufb     <= '0;
      rr_ptr   <= 1'b0;
    end else begin
      if (syn_vld_a & syn_rdy_a) begin
        bufa_vld <= 1'b1;
        bufa     <= syn_a;
      end else if (grant & ~sel) bufa_vld <= 1'b0;
      if (syn_vld_b & syn_rdy_b) begin
        bufb_vld <= 1'b1;
        bufb     <= syn_b;
      end else if (grant & sel) bufb_vld <= 1'b0;
      if (grant) rr_ptr <= ~sel;
    end
  end
  // in-flight job tracking, watchdog and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      tag       <= 1'b0;
      wdog      <= '0;
      err_wdog  <= 1'b0;
      err_stray <= 1'b0;
    end else begin
      if (issue) begin
        busy <= 1'b1;
        tag  <= sel;
        wdog <= '0;
      end else if (cap) busy <= 1'b0;
      else if (busy) begin
        if (wdog == 4'(WDOG_MAX)) begin
          busy     <= 1'b0;
          err_wdog <= 1'b1;
        end else wdog <= wdog + 4'd1;
      end
      if (kes_done & ~busy) err_stray <= 1'b1;
    end
  end
  // result buffer: engine capture or bypass write, held until drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld    <= 1'b0;
      res_lane   <= 1'b0;
      res_lambda <= '0;
      res_omega  <= '0;
    end else if (cap) begin
      res_vld    <= 1'b1;
      res_lane   <= tag;
      res_lambda <= kes_lambda;
      res_omega  <= kes_omega;
    end else if (byp) begin
      res_vld    <= 1'b1;
      res_lane   <= sel;
      res_lambda <= 24'h000001;
      res_omega  <= 16'h0000;
    end else if (res_vld & res_rdy) res_vld <= 1'b0;
  end
endmodule
